call_frame_ctrl: RTL and testbench
==================================

// Module: call_frame_ctrl
// PURPOSE
//  Call-frame controller that sits between the instruction decoder and the operand stack and drives
//  the stack's control-frame inputs. Accepts call/return commands, keeps a frame stack of
//  {return PC, caller local base}, and issues one-cycle call/return pulses with the allocation size
//  and frame-base tag. Publishes the current local base used to form local-memory addresses.
// PARAMETERS
//  ST_LOG2_DEPTH  8   log2 of operand-stack depth; all stack pointers are ST_LOG2_DEPTH+1 bits wide
//  FRAME_DEPTH    16  maximum number of nested frames held
//  FRAME_LOG2     4   log2(FRAME_DEPTH)
//  PC_WIDTH       16  return program-counter width
// PORTS
//  clk                 in   1               system clock, all logic on posedge
//  rst_n               in   1               synchronous, active-low reset
//  cmd_valid           in   1               command present
//  cmd_ready           out  1               block can accept a command this cycle
//  cmd_op              in   2               00 nop, 01 call, 10 return, 11 nop
//  cmd_ret_pc          in   PC_WIDTH        PC to resume at after callee returns (call only)
//  cmd_param_num       in   8               callee parameter count already on stack (call only)
//  cmd_local_num       in   8               callee declared non-parameter locals (call only)
//  top_pointer         in   ST_LOG2_DEPTH+1 operand-stack top pointer (from the stack's w_top_pointer)
//  os_call             out  1               call pulse to operand stack
//  os_return           out  1               return pulse to operand stack
//  os_allocate_size    out  8               locals to reserve; valid with os_call, else 0
//  os_function_stack_tag out ST_LOG2_DEPTH+1 frame base to restore; valid with os_return, else 0
//  local_base          out  ST_LOG2_DEPTH+1 stack index of local 0 of the current frame
//  ret_valid           out  1               pulse: ret_pc valid (with os_return)
//  ret_pc              out  PC_WIDTH        return PC popped from frame stack
//  frame_depth         out  FRAME_LOG2+1    number of live frames
//  program_done        out  1               sticky: return executed at depth 0
//  trap                out  1               sticky fault flag
//  trap_cause          out  2               01 frame overflow, 10 operand overflow, 11 param underflow
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state IDLE, all outputs 0 except cmd_ready; cmd_ready=1 from the
//    first cycle rst_n is high. Frame memory is not cleared. Reset mid-ISSUE cancels pending pulses.
//  - FSM: IDLE (cmd_ready=1) -> ISSUE (cmd_ready=0, one cycle) -> IDLE; IDLE -> TRAP or DONE on fault
//    or final return; TRAP and DONE hold cmd_ready=0 until reset.
//  - Accept = cmd_valid & cmd_ready in cycle T; top_pointer sampled in T. Ops 00/11 consumed in T,
//    no state change, stay IDLE.
//  - Call in T, checks in priority: frame_depth==FRAME_DEPTH -> cause 01; cmd_param_num>top_pointer
//    -> cause 11; (top_pointer+cmd_local_num) > 2^ST_LOG2_DEPTH (computed ST_LOG2_DEPTH+2 bits wide)
//    -> cause 10. Fault: enter TRAP in T+1, trap=1, cause latched, no pulse, frame state unchanged.
//  - Call OK: frame_mem[frame_depth] <= {cmd_ret_pc, local_base}; in T+1: os_call=1,
//    os_allocate_size=cmd_local_num, local_base=top_pointer-cmd_param_num, frame_depth+1.
//  - Return OK (frame_depth>0): in T+1 os_return=1, ret_valid=1,
//    os_function_stack_tag=old local_base, ret_pc/local_base from frame_mem[frame_depth-1], depth-1.
//  - Return at depth 0: enter DONE in T+1, program_done=1, no os_return/ret_valid.
//  - Pulses last exactly one cycle (T+1); pulse payloads are 0 outside the pulse. Throughput one
//    command per two cycles. Upstream must issue no push/pop to the operand stack in T+1.
//  - os_call and os_return never asserted together.
// TESTING
//  1 Reset held 2 cycles, release -> all outputs 0, cmd_ready=1, frame_depth=0.
//  2 Call top=5 param=2 local=3 ret_pc=0x0040 -> T+1 os_call=1 alloc=3 local_base=3 depth=1 ready=0; T+2 ready=1.
//  3 After 2, call top=9 param=1 local=0 ret_pc=0x0081 -> base=8 depth=2; return -> os_return=1
//    tag=8 ret_pc=0x0081 ret_valid=1, local_base=3 depth=1; 2nd return -> tag=3 ret_pc=0x0040 base=0.
//  4 16 valid calls then 17th -> trap=1 cause=01, no os_call, depth=16, ready=0 until rst_n low.
//  5 Call top=1 param=2 -> trap cause=11; separate run call top=250 param=0 local=10 -> cause 10.
//  6 Return at depth 0 -> program_done=1, os_return=0, ready=0; reset mid-ISSUE -> no pulse emitted.

Source files
------------

// File: rtl/call_frame_if.sv
// Command channel from the instruction decoder into the call-frame controller.
interface call_frame_if #(
    parameter int unsigned PC_WIDTH = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [PC_WIDTH-1:0] cmd_ret_pc;
    logic [7:0]          cmd_param_num;
    logic [7:0]          cmd_local_num;

    // Decoder side drives commands and observes ready
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_ret_pc,
        output cmd_param_num,
        output cmd_local_num,
        input  cmd_ready
    );

    // Controller side accepts commands
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_ret_pc,
        input  cmd_param_num,
        input  cmd_local_num,
        output cmd_ready
    );
endinterface

// File: rtl/call_frame_ctrl.sv
// Call-frame controller: tracks nested frames {return PC, caller local base} and
// drives one-cycle call/return pulses into the operand stack.
module call_frame_ctrl #(
    parameter int unsigned ST_LOG2_DEPTH = 8,
    parameter int unsigned FRAME_DEPTH   = 16,
    parameter int unsigned FRAME_LOG2    = 4,
    parameter int unsigned PC_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    call_frame_if.slave               cmd,
    input  logic [ST_LOG2_DEPTH:0]    top_pointer,
    output logic                      os_call,
    output logic                      os_return,
    output logic [7:0]                os_allocate_size,
    output logic [ST_LOG2_DEPTH:0]    os_function_stack_tag,
    output logic [ST_LOG2_DEPTH:0]    local_base,
    output logic                      ret_valid,
    output logic [PC_WIDTH-1:0]       ret_pc,
    output logic [FRAME_LOG2:0]       frame_depth,
    output logic                      program_done,
    output logic                      trap,
    output logic [1:0]                trap_cause
);

    localparam int unsigned ST_W = ST_LOG2_DEPTH + 1;
    localparam int unsigned DW   = FRAME_LOG2 + 1;
    // Compare width: one bit above the stack pointer, and never narrower than the 8-bit counts
    localparam int unsigned CW   = (ST_W + 1 > 9) ? ST_W + 1 : 9;
    localparam logic [CW-1:0] ST_CAP = CW'(2 ** ST_LOG2_DEPTH);

    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_RETURN = 2'b10;

    localparam logic [1:0] CAUSE_FRAME_OVF   = 2'b01;
    localparam logic [1:0] CAUSE_OPERAND_OVF = 2'b10;
    localparam logic [1:0] CAUSE_PARAM_UNF   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_TRAP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] ret_pc;
        logic [ST_W-1:0]     base;
    } frame_t;

    state_t                state;
    logic                  ready_q;
    frame_t                frame_mem [FRAME_DEPTH];

    logic                  accept;
    logic                  is_call;
    logic                  is_ret;
    logic                  frame_full;
    logic                  param_under;
    logic                  operand_over;
    logic                  call_ok;
    logic [1:0]            fault_cause;
    logic [FRAME_LOG2-1:0] wr_idx;
    logic [FRAME_LOG2-1:0] rd_idx;
    frame_t                top_frame;

    assign cmd.cmd_ready = ready_q;

    // Decode the accepted command and evaluate call admission checks in priority order
    always_comb begin
        accept       = cmd.cmd_valid & ready_q;
        is_call      = accept && (cmd.cmd_op == OP_CALL);
        is_ret       = accept && (cmd.cmd_op == OP_RETURN);
        frame_full   = (frame_depth == DW'(FRAME_DEPTH));
        param_under  = CW'(cmd.cmd_param_num) > CW'(top_pointer);
        operand_over = (CW'(top_pointer) + CW'(cmd.cmd_local_num)) > ST_CAP;
        call_ok      = is_call & ~frame_full & ~param_under & ~operand_over;
        fault_cause  = CAUSE_OPERAND_OVF;
        if (frame_full) begin
            fault_cause = CAUSE_FRAME_OVF;
        end else if (param_under) begin
            fault_cause = CAUSE_PARAM_UNF;
        end
        wr_idx    = FRAME_LOG2'(frame_depth);
        rd_idx    = FRAME_LOG2'(frame_depth - DW'(1));
        top_frame = frame_mem[rd_idx];
    end

    // Frame storage: push the caller context on an admitted call (not cleared by reset)
    always_ff @(posedge clk) begin
        if (call_ok) begin
            frame_mem[wr_idx] <= '{ret_pc: cmd.cmd_ret_pc, base: local_base};
        end
    end

    // Control FSM with registered pulses, payloads and sticky status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= S_IDLE;
            ready_q               <= 1'b1;
            os_call               <= 1'b0;
            os_return             <= 1'b0;
            os_allocate_size      <= '0;
            os_function_stack_tag <= '0;
            local_base            <= '0;
            ret_valid             <= 1'b0;
            ret_pc                <= '0;
            frame_depth           <= '0;
            program_done          <= 1'b0;
            trap                  <= 1'b0;
            trap_cause            <= '0;
        end else begin
            os_call               <= 1'b0;
            os_return             <= 1'b0;
            os_allocate_size      <= '0;
            os_function_stack_tag <= '0;
            ret_valid             <= 1'b0;
            ret_pc                <= '0;
            case (state)
                S_IDLE: begin
                    if (is_call) begin
                        ready_q <= 1'b0;
                        if (call_ok) begin
                            state            <= S_ISSUE;
                            os_call          <= 1'b1;
                            os_allocate_size <= cmd.cmd_local_num;
                            local_base       <= top_pointer - ST_W'(cmd.cmd_param_num);
                            frame_depth      <= frame_depth + DW'(1);
                        end else begin
                            state      <= S_TRAP;
                            trap       <= 1'b1;
                            trap_cause <= fault_cause;
                        end
                    end else if (is_ret) begin
                        ready_q <= 1'b0;
                        if (frame_depth != '0) begin
                            state                 <= S_ISSUE;
                            os_return             <= 1'b1;
                            ret_valid             <= 1'b1;
                            os_function_stack_tag <= local_base;
                            ret_pc                <= top_frame.ret_pc;
                            local_base            <= top_frame.base;
                            frame_depth           <= frame_depth - DW'(1);
                        end else begin
                            state        <= S_DONE;
                            program_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_frame_ctrl.sv
// Self-checking bench for call_frame_ctrl: directed scenarios plus a randomized
// call/return stream checked against a frame-stack reference model.
module tb_call_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  top_pointer;
    logic        os_call;
    logic        os_return;
    logic [7:0]  os_allocate_size;
    logic [8:0]  os_function_stack_tag;
    logic [8:0]  local_base;
    logic        ret_valid;
    logic [15:0] ret_pc;
    logic [4:0]  frame_depth;
    logic        program_done;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_cmp = 0;
    int n_err = 0;

    call_frame_if #(.PC_WIDTH(16)) cmd_bus ();

    call_frame_ctrl #(
        .ST_LOG2_DEPTH(8),
        .FRAME_DEPTH  (16),
        .FRAME_LOG2   (4),
        .PC_WIDTH     (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd                  (cmd_bus),
        .top_pointer          (top_pointer),
        .os_call              (os_call),
        .os_return            (os_return),
        .os_allocate_size     (os_allocate_size),
        .os_function_stack_tag(os_function_stack_tag),
        .local_base           (local_base),
        .ret_valid            (ret_valid),
        .ret_pc               (ret_pc),
        .frame_depth          (frame_depth),
        .program_done         (program_done),
        .trap                 (trap),
        .trap_cause           (trap_cause)
    );

    always #5 clk = ~clk;

    // Present one command for a single accept edge; returns just after that edge (T+1)
    task automatic send(input logic [1:0] op, input logic [15:0] pc, input logic [7:0] pn,
                        input logic [7:0] ln, input logic [8:0] top);
        @(negedge clk);
        cmd_bus.cmd_op        = op;
        cmd_bus.cmd_ret_pc    = pc;
        cmd_bus.cmd_param_num = pn;
        cmd_bus.cmd_local_num = ln;
        top_pointer           = top;
        cmd_bus.cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({os_call, os_return, os_allocate_size, os_function_stack_tag, local_base, ret_valid,
             ret_pc, frame_depth, program_done, trap, trap_cause} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got call=%0b ret=%0b alloc=%0d tag=%0d base=%0d rv=%0b pc=%h depth=%0d done=%0b trap=%0b cause=%0d, want all 0",
                     os_call, os_return, os_allocate_size, os_function_stack_tag, local_base,
                     ret_valid, ret_pc, frame_depth, program_done, trap, trap_cause);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready_now() !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %0b want 1", cmd_ready_now());
        end
    endtask

    function automatic logic cmd_ready_now();
        return cmd_bus.cmd_ready;
    endfunction

    task automatic test_nop();
        send(2'b11, 16'h1234, 8'd1, 8'd1, 9'd10);
        n_cmp++;
        if ({os_call, os_return, cmd_bus.cmd_ready, frame_depth} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL nop: got call=%0b ret=%0b ready=%0b depth=%0d want 0 0 1 0",
                     os_call, os_return, cmd_bus.cmd_ready, frame_depth);
        end
    endtask

    task automatic test_call_basic();
        send(2'b01, 16'h0040, 8'd2, 8'd3, 9'd5);
        n_cmp++;
        if ({os_call, os_return, os_allocate_size, local_base, frame_depth, cmd_bus.cmd_ready} !==
            {1'b1, 1'b0, 8'd3, 9'd3, 5'd1, 1'b0}) begin
            n_err++;
            $display("FAIL call_basic_t1: got call=%0b ret=%0b alloc=%0d base=%0d depth=%0d ready=%0b want 1 0 3 3 1 0",
                     os_call, os_return, os_allocate_size, local_base, frame_depth, cmd_bus.cmd_ready);
        end
        next_cycle();
        n_cmp++;
        if ({os_call, os_allocate_size, cmd_bus.cmd_ready} !== {1'b0, 8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL call_basic_t2: got call=%0b alloc=%0d ready=%0b want 0 0 1",
                     os_call, os_allocate_size, cmd_bus.cmd_ready);
        end
    endtask

    task automatic test_nested_return();
        send(2'b01, 16'h0081, 8'd1, 8'd0, 9'd9);
        n_cmp++;
        if ({os_call, local_base, frame_depth} !== {1'b1, 9'd8, 5'd2}) begin
            n_err++;
            $display("FAIL nested_call: got call=%0b base=%0d depth=%0d want 1 8 2",
                     os_call, local_base, frame_depth);
        end
        next_cycle();
        send(2'b10, 16'h0, 8'd0, 8'd0, 9'd9);
        n_cmp++;
        if ({os_return, os_call, os_function_stack_tag, ret_pc, ret_valid, local_base, frame_depth} !==
            {1'b1, 1'b0, 9'd8, 16'h0081, 1'b1, 9'd3, 5'd1}) begin
            n_err++;
            $display("FAIL return1: got ret=%0b call=%0b tag=%0d pc=%h rv=%0b base=%0d depth=%0d want 1 0 8 0081 1 3 1",
                     os_return, os_call, os_function_stack_tag, ret_pc, ret_valid, local_base, frame_depth);
        end
        next_cycle();
        n_cmp++;
        if ({os_return, ret_valid, os_function_stack_tag, ret_pc} !== '0) begin
            n_err++;
            $display("FAIL return1_clear: got ret=%0b rv=%0b tag=%0d pc=%h want all 0",
                     os_return, ret_valid, os_function_stack_tag, ret_pc);
        end
        send(2'b10, 16'h0, 8'd0, 8'd0, 9'd3);
        n_cmp++;
        if ({os_return, os_function_stack_tag, ret_pc, ret_valid, local_base, frame_depth} !==
            {1'b1, 9'd3, 16'h0040, 1'b1, 9'd0, 5'd0}) begin
            n_err++;
            $display("FAIL return2: got ret=%0b tag=%0d pc=%h rv=%0b base=%0d depth=%0d want 1 3 0040 1 0 0",
                     os_return, os_function_stack_tag, ret_pc, ret_valid, local_base, frame_depth);
        end
        next_cycle();
    endtask

    task automatic test_frame_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(2'b01, 16'(i), 8'd0, 8'd0, 9'(i));
            next_cycle();
        end
        n_cmp++;
        if (frame_depth !== 5'd16) begin
            n_err++;
            $display("FAIL fill_depth: got %0d want 16", frame_depth);
        end
        send(2'b01, 16'hBEEF, 8'd0, 8'd0, 9'd20);
        n_cmp++;
        if ({trap, trap_cause, os_call, frame_depth, cmd_bus.cmd_ready} !== {1'b1, 2'b01, 1'b0, 5'd16, 1'b0}) begin
            n_err++;
            $display("FAIL frame_ovf: got trap=%0b cause=%0d call=%0b depth=%0d ready=%0b want 1 1 0 16 0",
                     trap, trap_cause, os_call, frame_depth, cmd_bus.cmd_ready);
        end
        send(2'b10, 16'h0, 8'd0, 8'd0, 9'd0);
        repeat (3) next_cycle();
        n_cmp++;
        if ({cmd_bus.cmd_ready, os_return, trap, frame_depth} !== {1'b0, 1'b0, 1'b1, 5'd16}) begin
            n_err++;
            $display("FAIL trap_hold: got ready=%0b ret=%0b trap=%0b depth=%0d want 0 0 1 16",
                     cmd_bus.cmd_ready, os_return, trap, frame_depth);
        end
        do_reset();
        #1;
        n_cmp++;
        if ({cmd_bus.cmd_ready, trap, trap_cause, frame_depth, local_base} !== {1'b1, 1'b0, 2'b00, 5'd0, 9'd0}) begin
            n_err++;
            $display("FAIL trap_reset: got ready=%0b trap=%0b cause=%0d depth=%0d base=%0d want 1 0 0 0 0",
                     cmd_bus.cmd_ready, trap, trap_cause, frame_depth, local_base);
        end
    endtask

    task automatic test_param_underflow();
        do_reset();
        send(2'b01, 16'h0010, 8'd2, 8'd0, 9'd2);
        n_cmp++;
        if ({os_call, trap, local_base} !== {1'b1, 1'b0, 9'd0}) begin
            n_err++;
            $display("FAIL param_edge: got call=%0b trap=%0b base=%0d want 1 0 0", os_call, trap, local_base);
        end
        do_reset();
        send(2'b01, 16'h0010, 8'd2, 8'd0, 9'd1);
        n_cmp++;
        if ({trap, trap_cause, os_call, frame_depth} !== {1'b1, 2'b11, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL param_unf: got trap=%0b cause=%0d call=%0b depth=%0d want 1 3 0 0",
                     trap, trap_cause, os_call, frame_depth);
        end
    endtask

    task automatic test_operand_overflow();
        do_reset();
        send(2'b01, 16'h0020, 8'd0, 8'd6, 9'd250);
        n_cmp++;
        if ({os_call, trap, os_allocate_size} !== {1'b1, 1'b0, 8'd6}) begin
            n_err++;
            $display("FAIL operand_edge: got call=%0b trap=%0b alloc=%0d want 1 0 6", os_call, trap, os_allocate_size);
        end
        do_reset();
        send(2'b01, 16'h0020, 8'd0, 8'd10, 9'd250);
        n_cmp++;
        if ({trap, trap_cause, os_call, frame_depth} !== {1'b1, 2'b10, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL operand_ovf: got trap=%0b cause=%0d call=%0b depth=%0d want 1 2 0 0",
                     trap, trap_cause, os_call, frame_depth);
        end
    endtask

    task automatic test_program_done();
        do_reset();
        send(2'b10, 16'h0, 8'd0, 8'd0, 9'd0);
        n_cmp++;
        if ({program_done, os_return, ret_valid, cmd_bus.cmd_ready, trap} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL done: got done=%0b ret=%0b rv=%0b ready=%0b trap=%0b want 1 0 0 0 0",
                     program_done, os_return, ret_valid, cmd_bus.cmd_ready, trap);
        end
        repeat (2) next_cycle();
        n_cmp++;
        if ({program_done, cmd_bus.cmd_ready} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL done_hold: got done=%0b ready=%0b want 1 0", program_done, cmd_bus.cmd_ready);
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        // Reset coincides with the accept edge: nothing may be issued
        @(negedge clk);
        cmd_bus.cmd_op        = 2'b01;
        cmd_bus.cmd_ret_pc    = 16'h0099;
        cmd_bus.cmd_param_num = 8'd0;
        cmd_bus.cmd_local_num = 8'd4;
        top_pointer           = 9'd7;
        cmd_bus.cmd_valid     = 1'b1;
        rst_n                 = 1'b0;
        next_cycle();
        n_cmp++;
        if ({os_call, frame_depth, local_base, cmd_bus.cmd_ready} !== {1'b0, 5'd0, 9'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_accept: got call=%0b depth=%0d base=%0d ready=%0b want 0 0 0 1",
                     os_call, frame_depth, local_base, cmd_bus.cmd_ready);
        end
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        rst_n             = 1'b1;
        // Reset during the issue cycle returns everything to the idle state
        send(2'b01, 16'h0099, 8'd0, 8'd4, 9'd7);
        @(negedge clk);
        rst_n = 1'b0;
        next_cycle();
        n_cmp++;
        if ({os_call, os_allocate_size, frame_depth, local_base, cmd_bus.cmd_ready} !== {1'b0, 8'd0, 5'd0, 9'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_issue: got call=%0b alloc=%0d depth=%0d base=%0d ready=%0b want 0 0 0 0 1",
                     os_call, os_allocate_size, frame_depth, local_base, cmd_bus.cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Randomized call/return/nop stream against a frame-stack model
    task automatic test_random();
        logic [15:0] q_pc [$];
        logic [8:0]  q_base [$];
        logic [8:0]  m_base;
        int          kind;
        int          top;
        int          pn;
        int          ln;
        int          maxl;
        logic [15:0] pc;
        logic        e_call;
        logic        e_ret;
        logic [7:0]  e_alloc;
        logic [8:0]  e_tag;
        logic [15:0] e_pc;
        do_reset();
        m_base = 9'd0;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind >= 2 && kind <= 6 && q_pc.size() == 16) kind = 7;
            if (kind >= 7 && q_pc.size() == 0) kind = 2;
            e_call = 1'b0; e_ret = 1'b0; e_alloc = 8'd0; e_tag = 9'd0; e_pc = 16'd0;
            pc     = 16'($urandom);
            top    = int'($urandom_range(0, 256));
            if (kind < 2) begin
                send((kind == 0) ? 2'b00 : 2'b11, pc, 8'($urandom), 8'($urandom), 9'(top));
            end else if (kind <= 6) begin
                pn   = int'($urandom_range(0, (top > 255) ? 255 : top));
                maxl = 256 - top;
                ln   = int'($urandom_range(0, (maxl > 255) ? 255 : maxl));
                q_pc.push_back(pc);
                q_base.push_back(m_base);
                m_base  = 9'(top - pn);
                e_call  = 1'b1;
                e_alloc = 8'(ln);
                send(2'b01, pc, 8'(pn), 8'(ln), 9'(top));
            end else begin
                e_ret  = 1'b1;
                e_tag  = m_base;
                e_pc   = q_pc.pop_back();
                m_base = q_base.pop_back();
                send(2'b10, pc, 8'($urandom), 8'($urandom), 9'(top));
            end
            n_cmp++;
            if ({os_call, os_return, ret_valid, os_allocate_size, os_function_stack_tag, ret_pc,
                 local_base, frame_depth, cmd_bus.cmd_ready, trap} !==
                {e_call, e_ret, e_ret, e_alloc, e_tag, e_pc, m_base, 5'(q_pc.size()),
                 ~(e_call | e_ret), 1'b0}) begin
                n_err++;
                $display("FAIL random step %0d: got call=%0b ret=%0b rv=%0b alloc=%0d tag=%0d pc=%h base=%0d depth=%0d ready=%0b trap=%0b want call=%0b ret=%0b alloc=%0d tag=%0d pc=%h base=%0d depth=%0d",
                         i, os_call, os_return, ret_valid, os_allocate_size, os_function_stack_tag,
                         ret_pc, local_base, frame_depth, cmd_bus.cmd_ready, trap,
                         e_call, e_ret, e_alloc, e_tag, e_pc, m_base, q_pc.size());
            end
            if (e_call | e_ret) begin
                next_cycle();
                n_cmp++;
                if ({os_call, os_return, ret_valid, os_allocate_size, os_function_stack_tag, ret_pc,
                     cmd_bus.cmd_ready} !== {1'b0, 1'b0, 1'b0, 8'd0, 9'd0, 16'd0, 1'b1}) begin
                    n_err++;
                    $display("FAIL random_clear step %0d: got call=%0b ret=%0b rv=%0b alloc=%0d tag=%0d pc=%h ready=%0b want 0 0 0 0 0 0000 1",
                             i, os_call, os_return, ret_valid, os_allocate_size,
                             os_function_stack_tag, ret_pc, cmd_bus.cmd_ready);
                end
            end
        end
    endtask

    initial begin
        rst_n                 = 1'b0;
        top_pointer           = 9'd0;
        cmd_bus.cmd_valid     = 1'b0;
        cmd_bus.cmd_op        = 2'b00;
        cmd_bus.cmd_ret_pc    = 16'd0;
        cmd_bus.cmd_param_num = 8'd0;
        cmd_bus.cmd_local_num = 8'd0;
        test_reset();
        test_nop();
        test_call_basic();
        test_nested_return();
        test_frame_overflow();
        test_param_underflow();
        test_operand_overflow();
        test_program_done();
        test_reset_mid_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
